// File: rtl/pipe_stall_sequencer.sv
// pipe_stall_sequencer
//   Central stall/flush sequencer for the 5-stage F/D/X/M/W core. Merges hazard
//   stall requests, the branch-taken flush and the data-memory req/ack handshake
//   into per-pipeline-register load enables and bubble controls. Also owns halt,
//   the memory-timeout error state and a saturating stall-cycle counter.
// Parameters
//   MEM_TIMEOUT  max cycles in MEM_WAIT without mem_ack before ERR (>=1)
//   CNT_W        width of stall_cycles
// Ports
//   clk, rst                    clock (rising edge), async active-high reset
//   fd/dx/xm_stall_req          hazard-unit stall requests (increasing depth)
//   br_taken                    branch in D resolved taken
//   m_mem_op, mem_ack           memory op valid in M / memory completes access
//   w_halt                      halt instruction in W
//   pc_en, fd_en..mw_en         PC and pipeline register load enables
//   fd_flush, *_bubble          load bubble into the matching register
//   mem_req                     data memory request
//   halted, mem_timeout         sticky halt / timeout error flags
//   stall_cycles                cycles with pc_en=0 since reset, saturating
module pipe_stall_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fd_stall_req,
  input  logic             dx_stall_req,
  input  logic             xm_stall_req,
  input  logic             br_taken,
  input  logic             m_mem_op,
  input  logic             mem_ack,
  input  logic             w_halt,
  output logic             pc_en,
  output logic             fd_en,
  output logic             dx_en,
  output logic             xm_en,
  output logic             mw_en,
  output logic             fd_flush,
  output logic             dx_bubble,
  output logic             xm_bubble,
  output logic             mw_bubble,
  output logic             mem_req,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned TMR_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;
  localparam logic [1:0] ST_ERR      = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [TMR_W-1:0] timer;
  logic             mem_blocked;

  always_comb begin
    state_next  = state;
    pc_en       = 1'b0;
    fd_en       = 1'b0;
    dx_en       = 1'b0;
    xm_en       = 1'b0;
    mw_en       = 1'b0;
    fd_flush    = 1'b0;
    dx_bubble   = 1'b0;
    xm_bubble   = 1'b0;
    mw_bubble   = 1'b0;
    mem_req     = 1'b0;
    mem_blocked = 1'b0;

    case (state)
      ST_RUN: begin
        if (w_halt) begin
          // Halt wins over a same-cycle memory op: no request is issued.
          state_next = ST_HALT;
        end else begin
          if (m_mem_op) begin
            mem_req = 1'b1;
            if (!mem_ack) begin
              mem_blocked = 1'b1;
              mw_en       = 1'b1;
              mw_bubble   = 1'b1;
              state_next  = ST_MEM_WAIT;
            end
          end
          // A single-cycle access (ack in the same cycle) falls through to the
          // hazard chain; br_taken only takes effect when nothing stalls.
          if (!mem_blocked) begin
            if (xm_stall_req) begin
              mw_en     = 1'b1;
              mw_bubble = 1'b1;
            end else if (dx_stall_req) begin
              xm_en     = 1'b1;
              xm_bubble = 1'b1;
              mw_en     = 1'b1;
            end else if (fd_stall_req) begin
              dx_en     = 1'b1;
              dx_bubble = 1'b1;
              xm_en     = 1'b1;
              mw_en     = 1'b1;
            end else begin
              pc_en    = 1'b1;
              fd_en    = 1'b1;
              dx_en    = 1'b1;
              xm_en    = 1'b1;
              mw_en    = 1'b1;
              fd_flush = br_taken;
            end
          end
        end
      end

      ST_MEM_WAIT: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          pc_en      = 1'b1;
          fd_en      = 1'b1;
          dx_en      = 1'b1;
          xm_en      = 1'b1;
          mw_en      = 1'b1;
          state_next = ST_RUN;
        end else begin
          mw_en     = 1'b1;
          mw_bubble = 1'b1;
          if (timer == TMR_W'(MEM_TIMEOUT)) begin
            state_next = ST_ERR;
          end
        end
      end

      default: ;
    endcase

    // Outputs are forced quiet while reset is held, independent of state.
    if (rst) begin
      pc_en     = 1'b0;
      fd_en     = 1'b0;
      dx_en     = 1'b0;
      xm_en     = 1'b0;
      mw_en     = 1'b0;
      fd_flush  = 1'b0;
      dx_bubble = 1'b0;
      xm_bubble = 1'b0;
      mw_bubble = 1'b0;
      mem_req   = 1'b0;
    end
  end

  assign halted      = !rst && (state == ST_HALT);
  assign mem_timeout = !rst && (state == ST_ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // timer holds the number of cycles already spent waiting, starting at 1 on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (state_next == ST_MEM_WAIT) begin
      if (state == ST_MEM_WAIT) begin
        timer <= timer + 1'b1;
      end else begin
        timer <= TMR_W'(1);
      end
    end else begin
      timer <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if ((state == ST_RUN || state == ST_MEM_WAIT) && !pc_en
                 && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stall_sequencer.sv
// Scoreboard bench for pipe_stall_sequencer (MEM_TIMEOUT=4, CNT_W=4).
// Stimulus drives one input vector per cycle just after the rising edge and
// pushes the hand-computed outputs for that cycle; the monitor pops and
// compares on each falling edge.
module tb_pipe_stall_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fd_stall_req = 1'b0;
  logic       dx_stall_req = 1'b0;
  logic       xm_stall_req = 1'b0;
  logic       br_taken = 1'b0;
  logic       m_mem_op = 1'b0;
  logic       mem_ack = 1'b0;
  logic       w_halt = 1'b0;
  logic       pc_en, fd_en, dx_en, xm_en, mw_en;
  logic       fd_flush, dx_bubble, xm_bubble, mw_bubble;
  logic       mem_req, halted, mem_timeout;
  logic [3:0] stall_cycles;

  pipe_stall_sequencer #(
    .MEM_TIMEOUT(4),
    .CNT_W      (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fd_stall_req (fd_stall_req),
    .dx_stall_req (dx_stall_req),
    .xm_stall_req (xm_stall_req),
    .br_taken     (br_taken),
    .m_mem_op     (m_mem_op),
    .mem_ack      (mem_ack),
    .w_halt       (w_halt),
    .pc_en        (pc_en),
    .fd_en        (fd_en),
    .dx_en        (dx_en),
    .xm_en        (xm_en),
    .mw_en        (mw_en),
    .fd_flush     (fd_flush),
    .dx_bubble    (dx_bubble),
    .xm_bubble    (xm_bubble),
    .mw_bubble    (mw_bubble),
    .mem_req      (mem_req),
    .halted       (halted),
    .mem_timeout  (mem_timeout),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  // Output vector: {pc,fd,dx,xm,mw, fd_flush,dx_bub,xm_bub,mw_bub, mem_req,halted,mem_timeout}
  localparam logic [11:0] O_ZERO    = 12'b00000_0000_000;
  localparam logic [11:0] O_RUN     = 12'b11111_0000_000;
  localparam logic [11:0] O_RUN_REQ = 12'b11111_0000_100;
  localparam logic [11:0] O_FLUSH   = 12'b11111_1000_000;
  localparam logic [11:0] O_XM      = 12'b00001_0001_000;
  localparam logic [11:0] O_XM_REQ  = 12'b00001_0001_100;
  localparam logic [11:0] O_DX      = 12'b00011_0010_000;
  localparam logic [11:0] O_DX_REQ  = 12'b00011_0010_100;
  localparam logic [11:0] O_FD      = 12'b00111_0100_000;
  localparam logic [11:0] O_HALT    = 12'b00000_0000_010;
  localparam logic [11:0] O_ERR     = 12'b00000_0000_001;

  // Input vector: {rst, fd, dx, xm, br, mem_op, ack, halt}
  localparam logic [7:0] I_IDLE = 8'b0_000_0_000;

  typedef struct {
    logic [11:0] outs;
    logic [3:0]  cnt;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic step(input logic [7:0] in, input logic [11:0] o,
                      input logic [3:0] c, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    {rst, fd_stall_req, dx_stall_req, xm_stall_req,
     br_taken, m_mem_op, mem_ack, w_halt} = in;
    e.outs = o;
    e.cnt  = c;
    e.name = nm;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic [11:0] act;
      mon_e = sb.pop_front();
      act = {pc_en, fd_en, dx_en, xm_en, mw_en, fd_flush, dx_bubble, xm_bubble,
             mw_bubble, mem_req, halted, mem_timeout};
      checks++;
      if (act !== mon_e.outs) begin
        errors++;
        $display("FAIL %s outs: got %b expected %b", mon_e.name, act, mon_e.outs);
      end
      checks++;
      if (stall_cycles !== mon_e.cnt) begin
        errors++;
        $display("FAIL %s stall_cycles: got %0d expected %0d", mon_e.name,
                 stall_cycles, mon_e.cnt);
      end
    end
  end

  initial begin
    // Reset held with active requests: everything quiet.
    step(8'b1_100_1_100, O_ZERO, 4'd0, "rst_hold");
    // T1
    step(I_IDLE, O_RUN, 4'd0, "t1_run");
    // T2
    step(8'b0_111_0_000, O_XM, 4'd0, "t2_all_stall");
    step(I_IDLE, O_RUN, 4'd1, "t2_after");
    // T3
    step(8'b0_010_1_000, O_DX, 4'd1, "t3_br_dx");
    step(8'b0_000_1_000, O_FLUSH, 4'd2, "t3_br_alone");
    step(8'b0_100_0_000, O_FD, 4'd2, "fd_stall");
    step(I_IDLE, O_RUN, 4'd3, "idle_a");
    // Single-cycle memory access, alone and falling through to a dx stall.
    step(8'b0_000_0_110, O_RUN_REQ, 4'd3, "mem_1cyc");
    step(8'b0_010_0_110, O_DX_REQ, 4'd3, "mem_1cyc_dx");
    // T4, with halt and hazard requests ignored in MEM_WAIT.
    step(8'b0_000_0_100, O_XM_REQ, 4'd4, "t4_issue");
    step(8'b0_001_0_101, O_XM_REQ, 4'd5, "t4_wait1");
    step(8'b0_000_0_100, O_XM_REQ, 4'd6, "t4_wait2");
    step(8'b0_100_0_110, O_RUN_REQ, 4'd7, "t4_ack");
    step(I_IDLE, O_RUN, 4'd7, "t4_back_run");
    // Counter saturation at 15.
    for (int i = 0; i < 10; i++) begin
      step(8'b0_001_0_000, O_XM, (7 + i > 15) ? 4'd15 : 4'(7 + i), "sat_xm");
    end
    step(I_IDLE, O_RUN, 4'd15, "sat_hold");
    // T6 halt
    step(8'b1_000_0_000, O_ZERO, 4'd0, "rst_b");
    step(I_IDLE, O_RUN, 4'd0, "run_b");
    step(8'b0_000_0_101, O_ZERO, 4'd0, "t6_halt_memop");
    for (int i = 0; i < 3; i++) begin
      step(8'b0_001_1_100, O_HALT, 4'd1, "t6_halted");
    end
    // T5 timeout
    step(8'b1_000_0_000, O_ZERO, 4'd0, "rst_c");
    step(I_IDLE, O_RUN, 4'd0, "run_c");
    step(8'b0_000_0_100, O_XM_REQ, 4'd0, "t5_issue");
    for (int i = 1; i <= 4; i++) begin
      step(8'b0_000_0_100, O_XM_REQ, 4'(i), "t5_wait");
    end
    for (int i = 0; i < 20; i++) begin
      step(8'b0_000_0_100, O_ERR, 4'd5, "t5_err");
    end
    // Ack on the timeout cycle wins.
    step(8'b1_000_0_000, O_ZERO, 4'd0, "rst_d");
    step(I_IDLE, O_RUN, 4'd0, "run_d");
    step(8'b0_000_0_100, O_XM_REQ, 4'd0, "edge_issue");
    for (int i = 1; i <= 3; i++) begin
      step(8'b0_000_0_100, O_XM_REQ, 4'(i), "edge_wait");
    end
    step(8'b0_000_0_110, O_RUN_REQ, 4'd4, "edge_ack_at_limit");
    step(I_IDLE, O_RUN, 4'd4, "edge_back_run");
    // Reset in the middle of MEM_WAIT.
    step(8'b0_000_0_100, O_XM_REQ, 4'd4, "t6_issue");
    step(8'b0_000_0_100, O_XM_REQ, 4'd5, "t6_wait");
    step(8'b1_000_0_100, O_ZERO, 4'd0, "t6_rst_midwait");
    step(I_IDLE, O_RUN, 4'd0, "t6_after_rst");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
